// File: rtl/mcb_rd_pkg.sv
// Shared types and constants for the MCB port-1 burst read engine.
package mcb_rd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StStream,
        StFlush,
        StFin
    } rd_state_e;

    localparam logic [2:0] MCB_INSTR_RD = 3'b001;

    localparam int unsigned DEF_BURST_LEN = 32;
    localparam int unsigned BURST_BYTES = DEF_BURST_LEN * 4;
    localparam int unsigned OUT_W = $clog2(2 * DEF_BURST_LEN) + 1;

    function automatic int unsigned burst_bytes(input int unsigned len);
        return len * 4;
    endfunction

    // Holds up to two full bursts of outstanding words.
    function automatic int unsigned out_width(input int unsigned len);
        return $clog2(2 * len) + 1;
    endfunction

endpackage

// File: rtl/mcb_rd_cmd_issuer.sv
// Read-command issuer: burst address, bursts-left-to-issue count, and a
// single-cycle command strobe that respects the MCB command FIFO full flag.
module mcb_rd_cmd_issuer
    import mcb_rd_pkg::*;
#(
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [CNT_W-1:0]  num_bursts_i,
    input  logic              issue_req_i,
    input  logic              cmd_full_i,
    output logic              cmd_en_o,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [CNT_W-1:0]  remaining_o
);

    localparam logic [ADDR_W-1:0] StepBytes = ADDR_W'(burst_bytes(BURST_LEN));

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              armed_q, armed_d;

    // armed_q delays the strobe by one cycle after a request appears.
    assign cmd_en_o    = issue_req_i & armed_q & ~cmd_full_i;
    assign cmd_addr_o  = addr_q;
    assign remaining_o = remaining_q;

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        armed_d     = armed_q;
        if (load_i) begin
            addr_d      = {start_addr_i[ADDR_W-1:7], 7'b0};
            remaining_d = num_bursts_i;
            armed_d     = 1'b0;
        end else begin
            armed_d = issue_req_i & ~cmd_en_o;
            if (cmd_en_o) begin
                addr_d      = addr_q + StepBytes;
                remaining_d = remaining_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            remaining_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            armed_q     <= armed_d;
        end
    end

endmodule

// File: rtl/mcb_burst_reader.sv
// Autonomous MCB port-1 burst reader feeding a valid/ready word stream.
// Define MCB_RD_PREFETCH_EN to allow a second read command while a burst streams.
module mcb_burst_reader
    import mcb_rd_pkg::*;
#(
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk_ddr_fifo,
    input  logic              sys_rst_n,
    input  logic              calib_done,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  num_bursts,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              p1_cmd_en,
    output logic [2:0]        p1_cmd_instr,
    output logic [5:0]        p1_cmd_bl,
    output logic [ADDR_W-1:0] p1_cmd_byte_addr,
    input  logic              p1_cmd_full,
    output logic              p1_rd_en,
    input  logic [31:0]       p1_rd_data,
    input  logic              p1_rd_empty,
    input  logic              p1_rd_overflow,
    output logic [31:0]       m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int unsigned OutW = out_width(BURST_LEN);
    localparam int unsigned WcW  = $clog2(BURST_LEN);
    localparam logic [OutW-1:0] BurstWords = OutW'(BURST_LEN);
    localparam logic [WcW-1:0]  LastWord   = WcW'(BURST_LEN - 1);

    rd_state_e         state_q, state_d;
    logic [WcW-1:0]    word_cnt_q, word_cnt_d;
    logic [OutW-1:0]   out_q, out_d;
    logic              error_q, error_d;

    logic              accept;
    logic              stop;
    logic              issue_req;
    logic [CNT_W-1:0]  remaining;

    assign accept = (state_q == StIdle) & start & calib_done;
    assign stop   = abort | p1_rd_overflow | ~calib_done;

`ifdef MCB_RD_PREFETCH_EN
    // Second command only while at most one burst is still in flight.
    assign issue_req = (state_q == StCmd) |
                       ((state_q == StStream) & (remaining != '0) & (out_q <= BurstWords));
`else
    assign issue_req = (state_q == StCmd);
`endif

    mcb_rd_cmd_issuer #(
        .ADDR_W   (ADDR_W),
        .BURST_LEN(BURST_LEN),
        .CNT_W    (CNT_W)
    ) u_issuer (
        .clk_i       (clk_ddr_fifo),
        .rst_ni      (sys_rst_n),
        .load_i      (accept),
        .start_addr_i(start_addr),
        .num_bursts_i(num_bursts),
        .issue_req_i (issue_req),
        .cmd_full_i  (p1_cmd_full),
        .cmd_en_o    (p1_cmd_en),
        .cmd_addr_o  (p1_cmd_byte_addr),
        .remaining_o (remaining)
    );

    assign p1_cmd_instr = MCB_INSTR_RD;
    assign p1_cmd_bl    = 6'(BURST_LEN - 1);
    assign error        = error_q;

    // Outstanding words: a strobe in the same cycle as an abort still counts.
    always_comb begin
        out_d = out_q + (p1_cmd_en ? BurstWords : '0) - OutW'(p1_rd_en);
        if (accept) begin
            out_d = '0;
        end
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (accept) begin
            word_cnt_d = '0;
        end else if ((state_q == StStream) && p1_rd_en) begin
            word_cnt_d = (word_cnt_q == LastWord) ? '0 : word_cnt_q + 1'b1;
        end
    end

    always_comb begin
        error_d = error_q;
        if (accept) begin
            error_d = 1'b0;
        end else if ((state_q != StIdle) && (p1_rd_overflow || !calib_done)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_ddr_fifo or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            out_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            out_q      <= out_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (num_bursts == '0) ? StFin : StCmd;
                end
            end
            StCmd: begin
                if (stop) begin
                    state_d = StFlush;
                end else if (p1_cmd_en) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (stop) begin
                    state_d = StFlush;
                end else if (p1_rd_en && (word_cnt_q == LastWord) && (out_d == '0)) begin
                    state_d = (remaining != '0) ? StCmd : StFin;
                end
            end
            StFlush: begin
                if (out_q == '0) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StFin);
        m_valid  = 1'b0;
        m_data   = '0;
        p1_rd_en = 1'b0;
        unique case (state_q)
            StStream: begin
                m_valid  = ~p1_rd_empty;
                m_data   = p1_rd_data;
                p1_rd_en = ~p1_rd_empty & m_ready;
            end
            StFlush: begin
                p1_rd_en = ~p1_rd_empty & (out_q != '0);
            end
            default: begin
                m_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mcb_burst_reader.sv
// Self-checking bench for mcb_burst_reader against a queue-based MCB read-port model.
module tb_mcb_burst_reader;

    localparam int BL = 32;

    logic        clk_ddr_fifo = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        calib_done = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [29:0] start_addr = '0;
    logic [15:0] num_bursts = '0;
    logic        busy, done, error, p1_cmd_en, p1_rd_en, m_valid;
    logic [2:0]  p1_cmd_instr;
    logic [5:0]  p1_cmd_bl;
    logic [29:0] p1_cmd_byte_addr;
    logic        p1_cmd_full = 1'b0;
    logic [31:0] p1_rd_data = '0;
    logic        p1_rd_empty = 1'b1;
    logic        p1_rd_overflow = 1'b0;
    logic [31:0] m_data;
    logic        m_ready = 1'b0;

    always #5 clk_ddr_fifo = ~clk_ddr_fifo;

    mcb_burst_reader dut (
        .clk_ddr_fifo    (clk_ddr_fifo),
        .sys_rst_n       (sys_rst_n),
        .calib_done      (calib_done),
        .start           (start),
        .abort           (abort),
        .start_addr      (start_addr),
        .num_bursts      (num_bursts),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .p1_cmd_en       (p1_cmd_en),
        .p1_cmd_instr    (p1_cmd_instr),
        .p1_cmd_bl       (p1_cmd_bl),
        .p1_cmd_byte_addr(p1_cmd_byte_addr),
        .p1_cmd_full     (p1_cmd_full),
        .p1_rd_en        (p1_rd_en),
        .p1_rd_data      (p1_rd_data),
        .p1_rd_empty     (p1_rd_empty),
        .p1_rd_overflow  (p1_rd_overflow),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready)
    );

    int total = 0, passed = 0, fails = 0;
    int cyc = 0;
    // MCB model: words appear in the read FIFO a couple of cycles after a command.
    logic [31:0] fifo[$];
    int pend = 0, pdelay = 0, gen_seq = 0, pop_seq = 0;
    // Per-transaction observations
    logic [29:0] addr_log[$];
    int cmds, rx, flushed, done_cnt, start_cyc, first_cmd_cyc, done_cyc;
    int rd_empty_viol, full_viol, dbl_viol, lost_viol;
    logic prev_cmd = 1'b0, s_busy, busy_at_done;
    int rmode = 0, full_hold = 0, abort_at = -1, ovf_at = -1;
    logic full_rand = 1'b0, force_nr = 1'b0, ovf_fired = 1'b0, tog = 1'b0;
    logic [29:0] base_addr;

    function automatic logic [31:0] word_val(input int seq);
        return 32'(seq) * 32'h0101_0001 + 32'hA5A5_0000;
    endfunction

    function automatic logic [29:0] exp_addr(input logic [29:0] base, input int i);
        logic [29:0] b;
        b = base & ~30'h7F;
        return b + 30'(i * 128);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic sc, sr, sv, sd, sb;
        logic [29:0] sa;
        logic [31:0] smd;
        @(negedge clk_ddr_fifo);
        sc = p1_cmd_en; sa = p1_cmd_byte_addr; sr = p1_rd_en; sv = m_valid;
        smd = m_data; sd = done; sb = busy;
        if (sr && p1_rd_empty) rd_empty_viol++;
        if (sv && m_ready && !sr) lost_viol++;
        if (sc) begin
            if (cmds == 0) first_cmd_cyc = cyc;
            cmds++;
            addr_log.push_back(sa);
            if (p1_cmd_full) full_viol++;
            if (prev_cmd) dbl_viol++;
        end
        prev_cmd = sc;
        if (sr && sv) begin
            check("stream_word", 64'(smd), 64'(word_val(pop_seq)));
            pop_seq++;
            rx++;
        end else if (sr) begin
            flushed++;
            pop_seq++;
        end
        if (sd) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = sb;
        end
        s_busy = sb;
        @(posedge clk_ddr_fifo);
        #1;
        cyc++;
        if (sr && fifo.size() > 0) void'(fifo.pop_front());
        if (sc) begin
            pend += BL;
            pdelay = 2;
        end else if (pdelay > 0) begin
            pdelay--;
        end else if (pend > 0) begin
            fifo.push_back(word_val(gen_seq));
            gen_seq++;
            pend--;
        end
        p1_rd_empty = (fifo.size() == 0);
        p1_rd_data  = (fifo.size() > 0) ? fifo[0] : 32'h0;
        if (full_hold > 0) begin
            p1_cmd_full = 1'b1;
            full_hold--;
        end else begin
            p1_cmd_full = full_rand && ($urandom_range(0, 3) == 0);
        end
        if (abort_at >= 0 && rx >= abort_at) begin
            abort = 1'b1;
            force_nr = 1'b1;
        end
        if (ovf_at >= 0 && rx >= ovf_at && !ovf_fired) begin
            p1_rd_overflow = 1'b1;
            ovf_fired = 1'b1;
        end else begin
            p1_rd_overflow = 1'b0;
        end
        tog = ~tog;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = tog;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (force_nr) m_ready = 1'b0;
    endtask

    task automatic clear_obs();
        addr_log.delete();
        cmds = 0; rx = 0; flushed = 0; done_cnt = 0; first_cmd_cyc = -1; done_cyc = -1;
        rd_empty_viol = 0; full_viol = 0; dbl_viol = 0; lost_viol = 0;
        prev_cmd = 1'b0; busy_at_done = 1'b0;
    endtask

    task automatic run_txn(input logic [29:0] addr, input int nb, input int rm, input int fh,
                           input int ab, input int ov);
        clear_obs();
        base_addr = addr;
        rmode = rm; full_hold = fh; abort_at = ab; ovf_at = ov; ovf_fired = 1'b0;
        force_nr = 1'b0;
        m_ready = (rm == 0);
        start_addr = addr;
        num_bursts = 16'(nb);
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        step();
        check("busy_after_done", 64'(s_busy), 64'd0);
        abort = 1'b0; force_nr = 1'b0; abort_at = -1; ovf_at = -1;
    endtask

    // exp_cmds < 0 means the command count is not fixed for this transaction.
    task automatic check_txn(input string tag, input int exp_cmds, input int exp_rx,
                             input logic exp_err);
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd1);
        if (exp_cmds >= 0) check({tag, "_cmds"}, 64'(cmds), 64'(exp_cmds));
        for (int i = 0; i < addr_log.size(); i++)
            check({tag, "_addr"}, 64'(addr_log[i]), 64'(exp_addr(base_addr, i)));
        if (exp_rx >= 0) check({tag, "_rx"}, 64'(rx), 64'(exp_rx));
        check({tag, "_flushed"}, 64'(flushed), 64'(BL * cmds - rx));
        check({tag, "_fifo_drained"}, 64'(fifo.size() + pend), 64'd0);
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_rd_en_empty"}, 64'(rd_empty_viol), 64'd0);
        check({tag, "_cmd_while_full"}, 64'(full_viol), 64'd0);
        check({tag, "_cmd_double"}, 64'(dbl_viol), 64'd0);
        check({tag, "_word_lost"}, 64'(lost_viol), 64'd0);
    endtask

    initial begin
        clear_obs();
        #23;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_cmd_en", 64'(p1_cmd_en), 64'd0);
        check("rst_rd_en", 64'(p1_rd_en), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_cmd_addr", 64'(p1_cmd_byte_addr), 64'd0);
        check("rst_cmd_instr", 64'(p1_cmd_instr), 64'd1);
        check("rst_cmd_bl", 64'(p1_cmd_bl), 64'd31);
        @(posedge clk_ddr_fifo);
        #1;
        sys_rst_n = 1'b1;

        // start before calibration is ignored
        start_addr = 30'h100; num_bursts = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("nocal_busy", 64'(busy), 64'd0);
        check("nocal_cmds", 64'(cmds), 64'd0);
        check("nocal_done", 64'(done_cnt), 64'd0);
        check("nocal_error", 64'(error), 64'd0);
        calib_done = 1'b1;
        step();

        run_txn(30'h0000_0085, 3, 0, 0, -1, -1);
        check_txn("basic", 3, 96, 1'b0);
        check("basic_addr0", 64'(addr_log[0]), 64'h80);
        check("basic_latency", 64'((first_cmd_cyc - start_cyc) >= 2), 64'd1);

        run_txn(30'h0000_1234, 0, 0, 0, -1, -1);
        check_txn("zero", 0, 0, 1'b0);
        check("zero_done_lat", 64'(done_cyc - start_cyc), 64'd1);

        run_txn(30'h0000_4000, 2, 1, 5, -1, -1);
        check_txn("toggle", 2, 64, 1'b0);
        check("toggle_full_wait", 64'((first_cmd_cyc - start_cyc) >= 6), 64'd1);

        run_txn(30'h0002_0000, 4, 0, 0, 10, -1);
`ifdef MCB_RD_PREFETCH_EN
        check_txn("abort", -1, 10, 1'b0);
`else
        check_txn("abort", 1, 10, 1'b0);
        check("abort_flush22", 64'(flushed), 64'd22);
`endif

        run_txn(30'h3FFF_FF80, 2, 0, 0, -1, -1);
        check_txn("wrap", 2, 64, 1'b0);

        run_txn(30'h0000_0800, 2, 0, 0, 5, -1);
        abort_at = -1;
        run_txn(30'h0000_0800, 2, 2, 0, -1, 5);
        check_txn("ovf", -1, -1, 1'b1);
        check("ovf_sticky", 64'(error), 64'd1);

        run_txn(30'h0000_0C40, 1, 0, 0, -1, -1);
        check_txn("clear_err", 1, 32, 1'b0);

        full_rand = 1'b1;
        for (int t = 0; t < 4; t++) begin
            int nb;
            nb = $urandom_range(1, 3);
            run_txn(30'($urandom), nb, $urandom_range(0, 2), $urandom_range(0, 4), -1, -1);
            check_txn("rand", nb, nb * BL, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
